alu_result_collector: RTL and testbench
=======================================

# alu_result_collector

Downstream of the ALU control unit: watches the control unit's push strobes and END pulse, samples the datapath OUTBUS, and assembles each operation's words into one 2·WIDTH result. The control unit cannot be stalled, so completed results go into a 2-entry show-ahead buffer. The buffer is drained by a valid/ready consumer. Protocol violations and buffer overruns are flagged rather than silently absorbed.

## Interface
- WIDTH, 8, width of OUTBUS and of each A/Q word
- clk  in  1  single clock; all state updates on rising edge
- reset_input  in  1  synchronous, active-high reset
- start  in  1  same pulse as control-unit BEGIN; arms collector, latches op_code
- op_code  in  2  00 add, 01 sub, 10 mul, 11 div
- push_a  in  1  control unit pushAregister
- push_q  in  1  control unit pushQregister
- end_in  in  1  control unit END
- outbus  in  WIDTH  datapath OUTBUS
- res_valid  out  1  head entry available
- res_ready  in  1  consumer accepts head entry
- res_hi  out  WIDTH  upper result word
- res_lo  out  WIDTH  lower result word
- res_op  out  2  op_code of head entry
- res_err  out  1  head entry assembled from an inconsistent word set
- protocol_err  out  1  one-cycle pulse on a protocol violation
- overrun  out  1  sticky; a completed result was dropped because the buffer was full

## Operation
- FSM states: IDLE, ARMED.
  - IDLE→ARMED on start. Latch op_code and clear got_a, got_q, hi_r, lo_r.
  - ARMED→IDLE on the edge ending a cycle with end_in=1. This edge commits an entry.
  - start while ARMED: discard the partial result, pulse protocol_err, re-arm with the new op_code.
- Word capture:
  - push_x seen in cycle N means outbus is sampled in cycle N+1. Hold a 1-cycle registered pending flag for each push.
  - push_a and push_q high together: pulse protocol_err and ignore both.
- Word placement:
  - add/sub: res_lo=A; res_hi = WIDTH copies of A[WIDTH-1].
  - mul (A pushed, then Q): res_hi=A, res_lo=Q.
  - div (Q pushed, then A): res_hi=A (remainder), res_lo=Q (quotient).
  - Words never captured read 0.
- res_err=1 when:
  - the captured set ≠ expected set ({A} for add/sub, {A,Q} for mul/div), or
  - a word was captured twice (the later value wins).
- Pulse protocol_err and ignore the event for:
  - a push or end_in seen while IDLE, or
  - a pending sample landing while IDLE.
- End handling:
  - end_in in the same cycle as the final pending sample: the sample is included in the committed entry.
  - end_in with no pushes at all: commit an entry with res_err=1.

## Timing
- Reset values: res_valid=0, res_hi=0, res_lo=0, res_op=0, res_err=0, protocol_err=0, overrun=0. FSM goes to IDLE, buffer empties, pending flags clear.
- reset_input mid-operation drops everything, including buffered entries.
- Latency: commit at the edge ending the end_in cycle. res_valid goes high the next cycle if the buffer was empty.
- Handshake:
  - An entry pops on an edge with res_valid & res_ready.
  - Head outputs stay stable while res_valid & ~res_ready.
  - res_ready while empty has no effect.
- Full buffer:
  - Commit with no pop in the same cycle: drop the entry and set overrun.
  - Commit and pop in the same cycle: both take effect, count stays 2.
- Empty buffer: a commit is visible the next cycle; there is no same-cycle bypass.
- Pointers are 1 bit and wrap; count is 0..2.

## Structure
- alu_pkg holds:
  - op-code constants OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - FSM state encoding
  - default WIDTH
  - expected-word-set function per op
- Sub-module result_fifo2: 2-entry show-ahead FIFO with payload {op, err, hi, lo} and a drop-on-full output that feeds overrun.
- The top level contains only the FSM, the pending flags and assembly.

## Test plan
- add, op 00: push_a, then outbus=0x85 next cycle with end_in → one cycle later res_valid=1, res_hi=0xFF, res_lo=0x85, res_op=00, res_err=0.
- mul, op 10: A=0x12, then Q=0x34 (end_in with the Q sample) → res_hi=0x12, res_lo=0x34, res_err=0.
- div, op 11: Q=0x07, then A=0x03 → res_hi=0x03, res_lo=0x07.
- res_ready=0 while three add results complete (0x01, 0x02, 0x03):
  - overrun=1 after the third; outputs held stable.
  - Then res_ready=1 → pops 0x01 then 0x02, then res_valid=0.
- Errors:
  - push_a while IDLE → protocol_err high exactly one cycle, no entry.
  - mul ending with only A=0x55 → entry hi=0x55, lo=0x00, res_err=1.
- Reset:
  - reset_input one cycle after push_a in ARMED → all outputs 0 next cycle.
  - A following sub with A=0x10 yields a clean entry: hi=0x00, lo=0x10, op=01.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and helpers for the ALU result collector: op codes, FSM
// encoding, default datapath width and the word set each op must deliver.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    // Returns the required capture mask as {q, a}.
    function automatic logic [1:0] expected_set(input logic [1:0] op);
        case (op)
            OP_MUL, OP_DIV: expected_set = 2'b11;
            default:        expected_set = 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry show-ahead FIFO for assembled results. Writes arriving while full
// (with no simultaneous pop) are dropped and flagged on drop for one cycle.
module result_fifo2 #(
    parameter int DW = 19
) (
    input  logic          clk,
    input  logic          reset_input,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          drop
);

    logic [DW-1:0] mem_reg [2];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;
    logic [1:0]    count_next;
    logic          pop;
    logic          accept;

    assign rd_valid = (count_reg != 2'd0);
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot the write needs.
    assign accept   = wr_en & ((count_reg != 2'd2) | pop);
    assign drop     = wr_en & ~accept;
    assign rd_data  = rd_valid ? mem_reg[rd_ptr_reg] : '0;

    always_comb begin
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_input) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (accept) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)    rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Collects A/Q words pushed by the ALU control unit, assembles one 2*WIDTH
// result per operation and queues it for a valid/ready consumer.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_input,
    input  logic             start,
    input  logic [1:0]       op_code,
    input  logic             push_a,
    input  logic             push_q,
    input  logic             end_in,
    input  logic [WIDTH-1:0] outbus,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [1:0]       res_op,
    output logic             res_err,
    output logic             protocol_err,
    output logic             overrun
);

    localparam int DW = 3 + 2 * WIDTH;

    state_e           state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next, q_reg, q_next;
    logic             got_a_reg, got_a_next, got_q_reg, got_q_next;
    logic             dup_reg, dup_next;
    logic             pend_a_reg, pend_q_reg, pend_a_next, pend_q_next;
    logic             protocol_err_reg, overrun_reg;
    logic             perr, commit, drop, two_word;
    logic [WIDTH-1:0] commit_hi, commit_lo;
    logic             commit_err;
    logic [DW-1:0]    head;

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        q_next      = q_reg;
        got_a_next  = got_a_reg;
        got_q_next  = got_q_reg;
        dup_next    = dup_reg;
        perr        = 1'b0;
        commit      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (push_a | push_q | end_in | pend_a_reg | pend_q_reg) perr = 1'b1;
                if (start) begin
                    state_next = ST_ARMED;
                    op_next    = op_code;
                    a_next     = '0;
                    q_next     = '0;
                    got_a_next = 1'b0;
                    got_q_next = 1'b0;
                    dup_next   = 1'b0;
                end
            end
            default: begin
                // A restart discards the partial result, including any sample landing now.
                if (start) begin
                    perr       = 1'b1;
                    op_next    = op_code;
                    a_next     = '0;
                    q_next     = '0;
                    got_a_next = 1'b0;
                    got_q_next = 1'b0;
                    dup_next   = 1'b0;
                end else begin
                    if (pend_a_reg) begin
                        a_next     = outbus;
                        got_a_next = 1'b1;
                        if (got_a_reg) dup_next = 1'b1;
                    end
                    if (pend_q_reg) begin
                        q_next     = outbus;
                        got_q_next = 1'b1;
                        if (got_q_reg) dup_next = 1'b1;
                    end
                    if (end_in) begin
                        commit     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase
        if (push_a & push_q) perr = 1'b1;
    end

    assign pend_a_next = (state_reg == ST_ARMED) & push_a & ~push_q;
    assign pend_q_next = (state_reg == ST_ARMED) & push_q & ~push_a;

    // The committed entry uses the _next words so a sample landing with end_in is included.
    assign two_word   = (op_reg == OP_MUL) | (op_reg == OP_DIV);
    assign commit_hi  = two_word ? a_next : {WIDTH{a_next[WIDTH-1]}};
    assign commit_lo  = two_word ? q_next : a_next;
    assign commit_err = ({got_q_next, got_a_next} != expected_set(op_reg)) | dup_next;

    always_ff @(posedge clk) begin
        if (reset_input) begin
            state_reg        <= ST_IDLE;
            op_reg           <= 2'b00;
            a_reg            <= '0;
            q_reg            <= '0;
            got_a_reg        <= 1'b0;
            got_q_reg        <= 1'b0;
            dup_reg          <= 1'b0;
            pend_a_reg       <= 1'b0;
            pend_q_reg       <= 1'b0;
            protocol_err_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            op_reg           <= op_next;
            a_reg            <= a_next;
            q_reg            <= q_next;
            got_a_reg        <= got_a_next;
            got_q_reg        <= got_q_next;
            dup_reg          <= dup_next;
            pend_a_reg       <= pend_a_next;
            pend_q_reg       <= pend_q_next;
            protocol_err_reg <= perr;
            overrun_reg      <= overrun_reg | drop;
        end
    end

    result_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk         (clk),
        .reset_input (reset_input),
        .wr_en       (commit),
        .wr_data     ({op_reg, commit_err, commit_hi, commit_lo}),
        .rd_ready    (res_ready),
        .rd_valid    (res_valid),
        .rd_data     (head),
        .drop        (drop)
    );

    assign {res_op, res_err, res_hi, res_lo} = head;
    assign protocol_err = protocol_err_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed scenarios with literal expectations
// plus randomized operations checked every cycle against a behavioural model.
module tb_alu_result_collector;

    logic       clk = 1'b0;
    logic       reset_input = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op_code = 2'b00;
    logic       push_a = 1'b0;
    logic       push_q = 1'b0;
    logic       end_in = 1'b0;
    logic [7:0] outbus = 8'h00;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_hi;
    logic [7:0] res_lo;
    logic [1:0] res_op;
    logic       res_err;
    logic       protocol_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    bit rnd_ready = 1'b0;

    alu_result_collector #(
        .WIDTH(8)
    ) dut (
        .clk          (clk),
        .reset_input  (reset_input),
        .start        (start),
        .op_code      (op_code),
        .push_a       (push_a),
        .push_q       (push_q),
        .end_in       (end_in),
        .outbus       (outbus),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_hi       (res_hi),
        .res_lo       (res_lo),
        .res_op       (res_op),
        .res_err      (res_err),
        .protocol_err (protocol_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [1:0] op;
        logic       err;
    } ent_t;

    ent_t       m_q[$];
    bit         m_live = 1'b0;
    bit         m_armed = 1'b0;
    logic [1:0] m_op = 2'b00;
    int         m_acnt = 0;
    int         m_qcnt = 0;
    logic [7:0] m_aval = 8'h00;
    logic [7:0] m_qval = 8'h00;
    bit         m_pa = 1'b0;
    bit         m_pq = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_perr = 1'b0;
    bit         s_err, s_la, s_lq, s_pop, s_commit, s_was_armed;
    ent_t       s_e;

    function automatic ent_t build_entry();
        ent_t e;
        logic [7:0] a;
        logic [7:0] q;
        a = (m_acnt > 0) ? m_aval : 8'h00;
        q = (m_qcnt > 0) ? m_qval : 8'h00;
        e.op = m_op;
        if (m_op < 2) begin
            e.lo = a;
            e.hi = a[7] ? 8'hFF : 8'h00;
        end else begin
            e.hi = a;
            e.lo = q;
        end
        // Exactly one A, plus exactly one Q for mul/div and none otherwise.
        e.err = !(m_acnt == 1 && m_qcnt == ((m_op >= 2) ? 1 : 0));
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset_input) begin
            m_live  = 1'b1;
            m_armed = 1'b0;
            m_pa    = 1'b0;
            m_pq    = 1'b0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
            m_q.delete();
        end else begin
            s_err       = 1'b0;
            s_commit    = 1'b0;
            s_la        = m_pa;
            s_lq        = m_pq;
            s_was_armed = m_armed;
            s_pop       = (m_q.size() > 0) && res_ready;
            if (!s_was_armed) begin
                if (push_a || push_q || end_in || s_la || s_lq) s_err = 1'b1;
                if (start) begin
                    m_armed = 1'b1; m_op = op_code; m_acnt = 0; m_qcnt = 0;
                end
            end else if (start) begin
                s_err = 1'b1; m_op = op_code; m_acnt = 0; m_qcnt = 0;
            end else begin
                if (s_la) begin m_acnt++; m_aval = outbus; end
                if (s_lq) begin m_qcnt++; m_qval = outbus; end
                if (end_in) begin
                    s_e = build_entry(); s_commit = 1'b1; m_armed = 1'b0;
                end
            end
            if (push_a && push_q) s_err = 1'b1;
            m_pa = s_was_armed && push_a && !push_q;
            m_pq = s_was_armed && push_q && !push_a;
            if (s_pop) void'(m_q.pop_front());
            if (s_commit) begin
                if (m_q.size() < 2) m_q.push_back(s_e);
                else m_ovr = 1'b1;
            end
            m_perr = s_err;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_valid", res_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("model_hi", res_hi, m_q[0].hi);
                chk("model_lo", res_lo, m_q[0].lo);
                chk("model_op", res_op, m_q[0].op);
                chk("model_err", res_err, m_q[0].err);
            end
            chk("model_protocol_err", protocol_err, m_perr);
            chk("model_overrun", overrun, m_ovr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic t_start(input logic [1:0] op);
        start = 1'b1; op_code = op;
        cyc();
        start = 1'b0;
    endtask

    task automatic t_add(input logic [1:0] op, input logic [7:0] a);
        t_start(op);
        push_a = 1'b1;
        cyc();
        push_a = 1'b0; outbus = a; end_in = 1'b1;
        cyc();
        end_in = 1'b0;
    endtask

    task automatic t_two(input logic [1:0] op, input bit a_first, input logic [7:0] w1, input logic [7:0] w2);
        t_start(op);
        push_a = a_first; push_q = !a_first;
        cyc();
        outbus = w1; push_a = !a_first; push_q = a_first;
        cyc();
        push_a = 1'b0; push_q = 1'b0; outbus = w2; end_in = 1'b1;
        cyc();
        end_in = 1'b0;
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_hi"}, res_hi, 0);
        chk({tag, "_lo"}, res_lo, 0);
        chk({tag, "_op"}, res_op, 0);
        chk({tag, "_err"}, res_err, 0);
        chk({tag, "_perr"}, protocol_err, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        logic [1:0] op;
        logic [7:0] w1, w2;
        int kind;

        cyc(); cyc();
        reset_input = 1'b0;
        chk_zero("reset");

        t_add(2'b00, 8'h85);
        chk("add_valid", res_valid, 1); chk("add_hi", res_hi, 8'hFF);
        chk("add_lo", res_lo, 8'h85); chk("add_op", res_op, 2'b00); chk("add_err", res_err, 0);
        pop_one();
        chk("add_popped", res_valid, 0);

        t_two(2'b10, 1'b1, 8'h12, 8'h34);
        chk("mul_hi", res_hi, 8'h12); chk("mul_lo", res_lo, 8'h34); chk("mul_err", res_err, 0);
        pop_one();

        t_two(2'b11, 1'b0, 8'h07, 8'h03);
        chk("div_hi", res_hi, 8'h03); chk("div_lo", res_lo, 8'h07); chk("div_op", res_op, 2'b11);
        pop_one();

        t_add(2'b00, 8'h01);
        t_add(2'b00, 8'h02);
        chk("full_no_overrun", overrun, 0);
        t_add(2'b00, 8'h03);
        chk("overrun_set", overrun, 1); chk("overrun_head_lo", res_lo, 8'h01);
        chk("overrun_head_valid", res_valid, 1);
        cyc();
        chk("overrun_hold_lo", res_lo, 8'h01);
        res_ready = 1'b1;
        cyc();
        chk("pop_second_lo", res_lo, 8'h02);
        cyc();
        chk("drained_valid", res_valid, 0);
        res_ready = 1'b0;

        push_a = 1'b1;
        cyc();
        push_a = 1'b0;
        chk("idle_push_perr", protocol_err, 1); chk("idle_push_no_entry", res_valid, 0);
        cyc();
        chk("idle_push_perr_clear", protocol_err, 0);

        t_add(2'b10, 8'h55);
        chk("mul_partial_hi", res_hi, 8'h55); chk("mul_partial_lo", res_lo, 8'h00);
        chk("mul_partial_err", res_err, 1);
        pop_one();

        t_add(2'b00, 8'h22);
        t_start(2'b01);
        push_a = 1'b1;
        cyc();
        push_a = 1'b0; reset_input = 1'b1;
        cyc();
        reset_input = 1'b0;
        chk_zero("midreset");
        t_add(2'b01, 8'h10);
        chk("sub_hi", res_hi, 8'h00); chk("sub_lo", res_lo, 8'h10);
        chk("sub_op", res_op, 2'b01); chk("sub_err", res_err, 0);
        pop_one();

        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op   = 2'($urandom_range(0, 3));
            w1   = 8'($urandom);
            w2   = 8'($urandom);
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3, 4: begin
                    if (op < 2) t_add(op, w1);
                    else t_two(op, op == 2'b10, w1, w2);
                end
                5: begin
                    t_start(op);
                    end_in = 1'b1; cyc(); end_in = 1'b0;
                end
                6: begin
                    t_start(op);
                    push_a = 1'b1; cyc();
                    outbus = w1; cyc();
                    push_a = 1'b0; outbus = w2; end_in = 1'b1; cyc();
                    end_in = 1'b0;
                end
                7: begin
                    t_start(op);
                    push_a = 1'b1; push_q = 1'b1; cyc();
                    push_a = 1'b0; push_q = 1'b0; end_in = 1'b1; cyc();
                    end_in = 1'b0;
                end
                8: begin
                    t_start(op);
                    push_a = 1'b1; cyc();
                    push_a = 1'b0; outbus = w1;
                    t_add(2'($urandom_range(0, 1)), w2);
                end
                default: begin
                    push_a = 1'($urandom_range(0, 1));
                    push_q = 1'($urandom_range(0, 1));
                    end_in = 1'($urandom_range(0, 1));
                    cyc();
                    push_a = 1'b0; push_q = 1'b0; end_in = 1'b0;
                end
            endcase
            repeat ($urandom_range(0, 2)) cyc();
        end
        rnd_ready = 1'b0;
        res_ready = 1'b1;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
